bcd2bin: RTL and testbench

Sequential packed-BCD to binary converter, the inverse of the existing `bin2bcd` block. It accepts one packed BCD word with a valid strobe and runs a reverse double-dabble (shift-right / subtract-3) iteration, one bit per clock. It returns the binary value with a one-cycle valid pulse and flags invalid digits or overflow. It sits on the same `sclk` domain as `bin2bcd` and takes the same parameter pair, so the two blocks round-trip.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd2bin_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd2bin.sv | 121 ++++++++++++
 tb/tb_bcd2bin.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM state type for the bcd2bin / bin2bcd pair.
// Reverse conversion (bcd2bin) corrects nibbles >= 8 by subtracting 3;
// forward conversion (bin2bcd) corrects nibbles >= 5 by adding 3.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_FWD_THRESH = 4'd5;

  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > BCD_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Operand/result bus of the BCD-to-binary converter.
//   bcd_vld/bcd_data : operand strobe and packed BCD word (master -> slave)
//   busy             : conversion in flight, operands dropped (slave -> master)
//   bin_vld/bin_data : one-cycle result pulse and held binary value
//   err              : invalid digit or overflow, qualified by bin_vld
interface bcd2bin_if #(
  parameter int BIN_WIDTH = 7,
  parameter int BCD_WIDTH = 8
);
  logic                 bcd_vld;
  logic [BCD_WIDTH-1:0] bcd_data;
  logic                 busy;
  logic                 bin_vld;
  logic [BIN_WIDTH-1:0] bin_data;
  logic                 err;

  modport master (
    output bcd_vld, bcd_data,
    input  busy, bin_vld, bin_data, err
  );

  modport slave (
    input  bcd_vld, bcd_data,
    output busy, bin_vld, bin_data, err
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Single-nibble correction for reverse double-dabble: a nibble >= 8 after
// the right shift gets 3 subtracted (4-bit, no borrow into the next nibble).
//   din  : shifted nibble
//   dout : corrected nibble
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_VAL) : din;
endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter, one shift per clock.
//   sclk    : clock, rising edge
//   s_rst_n : synchronous active-low reset
//   bus     : slave side of bcd2bin_if (operand in, result out)
// Latency from accept edge to bin_vld is BIN_WIDTH+1 cycles.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 7,
  parameter int BCD_WIDTH = 8
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  bcd2bin_if.slave    bus
);
  localparam int NDIG  = BCD_WIDTH / 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  bcd_state_e           state_q, state_d;
  logic [BCD_WIDTH-1:0] bcd_r;
  logic [BIN_WIDTH-1:0] bin_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 inv_r;
  logic                 busy_r, vld_r, err_r;
  logic [BIN_WIDTH-1:0] data_r;

  logic                 do_load, do_shift, do_finish, last_shift;
  logic                 inv_in, done_err;
  logic [BCD_WIDTH-1:0] sh_bcd, adj_bcd;
  logic [BIN_WIDTH-1:0] sh_bin;

  // Whole {bcd_r, bin_r} register shifted right by one.
  assign sh_bcd = {1'b0, bcd_r[BCD_WIDTH-1:1]};
  assign sh_bin = {bcd_r[0], bin_r[BIN_WIDTH-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sh_bcd[4*g +: 4]),
      .dout (adj_bcd[4*g +: 4])
    );
  end

  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_invalid(bus.bcd_data[4*i +: 4])) inv_in = 1'b1;
    end
  end

  // Anything left in the BCD half after all shifts means value >= 2^BIN_WIDTH.
  assign done_err   = inv_r | (|bcd_r);
  assign last_shift = (cnt_r == CNT_W'(BIN_WIDTH - 1));

  always_ff @(posedge sclk) begin
    if (!s_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bcd_vld) begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (last_shift) state_d = DONE;
      end
      DONE: begin
        do_finish = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      bcd_r  <= '0;
      bin_r  <= '0;
      cnt_r  <= '0;
      inv_r  <= 1'b0;
      busy_r <= 1'b0;
      vld_r  <= 1'b0;
      err_r  <= 1'b0;
      data_r <= '0;
    end else begin
      vld_r <= 1'b0;
      err_r <= 1'b0;
      if (do_load) begin
        bcd_r  <= bus.bcd_data;
        bin_r  <= '0;
        inv_r  <= inv_in;
        cnt_r  <= '0;
        busy_r <= 1'b1;
      end
      if (do_shift) begin
        bcd_r <= adj_bcd;
        bin_r <= sh_bin;
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (do_finish) begin
        vld_r  <= 1'b1;
        err_r  <= done_err;
        data_r <= done_err ? '0 : bin_r;
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.bin_vld  = vld_r;
  assign bus.err      = err_r;
  assign bus.bin_data = data_r;
endmodule

// File: tb/tb_bcd2bin.sv
module tb_bcd2bin;
  localparam int BW = 7;

  logic sclk = 1'b0;
  logic s_rst_n;

  bcd2bin_if #(.BIN_WIDTH(7), .BCD_WIDTH(8)) bus ();
  bcd2bin_if #(.BIN_WIDTH(6), .BCD_WIDTH(8)) bus6 ();

  bcd2bin #(.BIN_WIDTH(7), .BCD_WIDTH(8)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  bcd2bin #(.BIN_WIDTH(6), .BCD_WIDTH(8)) dut6 (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus6)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit chk_en = 0;

  // Reference model state: one pending operand plus reset bookkeeping.
  bit pend = 0;
  int acc_edge = -1000;
  int exp_val = 0;
  bit exp_err = 0;
  int rst_edge = -1;
  int free_at = 0;
  int held = 0;

  function automatic void ref_conv(input logic [7:0] d, input int bw,
                                   output int val, output bit e);
    int hi, lo, v;
    bit bad;
    hi  = int'(d[7:4]);
    lo  = int'(d[3:0]);
    bad = (hi > 9) || (lo > 9);
    v   = hi * 10 + lo;
    e   = bad || (v >= (1 << bw));
    val = e ? 0 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Model reaction to the inputs sampled at edge e.
  task automatic model_edge(input bit vld, input logic [7:0] d, input bit rstn, input int e);
    if (!rstn) begin
      pend     = 0;
      rst_edge = e;
      free_at  = e + 1;
    end else if (vld && e >= free_at) begin
      pend     = 1;
      acc_edge = e;
      ref_conv(d, BW, exp_val, exp_err);
      free_at  = e + BW + 2;
    end
  endtask

  task automatic step(input bit vld, input logic [7:0] d, input bit rstn);
    bus.bcd_vld  = vld;
    bus.bcd_data = d;
    s_rst_n      = rstn;
    @(posedge sclk);
    edge_n++;
    model_edge(vld, d, rstn, edge_n);
    #1;
    bus.bcd_vld  = 1'b0;
    bus6.bcd_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  always @(negedge sclk) begin
    if (chk_en) begin
      int n, eb, ev, ee;
      n = edge_n;
      if (n == rst_edge) begin
        eb = 0; ev = 0; ee = 0; held = 0;
      end else begin
        eb = (pend && n >= acc_edge && n <= acc_edge + BW) ? 1 : 0;
        ev = (pend && n == acc_edge + BW + 1) ? 1 : 0;
        ee = (ev == 1) ? int'(exp_err) : 0;
        if (ev == 1) held = exp_val;
      end
      check("busy", int'(bus.busy), eb);
      check("bin_vld", int'(bus.bin_vld), ev);
      check("err", int'(bus.err), ee);
      check("bin_data", int'(bus.bin_data), held);
    end
  end

  task automatic run6(input logic [7:0] d, input int exp_v, input bit exp_e);
    int acc, seen;
    bus6.bcd_vld  = 1'b1;
    bus6.bcd_data = d;
    step(1'b0, 8'h00, 1'b1);
    acc  = edge_n;
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(negedge sclk);
      if (bus6.bin_vld) begin
        seen = 1;
        check("w6_latency", edge_n - acc, 7);
        check("w6_data", int'(bus6.bin_data), exp_v);
        check("w6_err", int'(bus6.err), int'(exp_e));
      end
      step(1'b0, 8'h00, 1'b1);
    end
    check("w6_result_seen", seen, 1);
    idle(2);
  endtask

  initial begin
    int v;
    bit e;
    logic [7:0] dd;

    bus.bcd_vld   = 1'b0;
    bus.bcd_data  = 8'h00;
    bus6.bcd_vld  = 1'b0;
    bus6.bcd_data = 8'h00;
    s_rst_n       = 1'b0;

    // Pin the reference model against hand-computed values.
    ref_conv(8'h30, 7, v, e); check("pin_30_val", v, 30); check("pin_30_err", int'(e), 0);
    ref_conv(8'h99, 7, v, e); check("pin_99_val", v, 99); check("pin_99_err", int'(e), 0);
    ref_conv(8'h3A, 7, v, e); check("pin_3a_val", v, 0);  check("pin_3a_err", int'(e), 1);
    ref_conv(8'hF0, 7, v, e); check("pin_f0_err", int'(e), 1);
    ref_conv(8'h64, 6, v, e); check("pin_64w6_err", int'(e), 1);
    ref_conv(8'h63, 6, v, e); check("pin_63w6_val", v, 63);

    step(1'b0, 8'h00, 1'b0);
    chk_en = 1;
    step(1'b0, 8'h00, 1'b0);
    idle(2);

    step(1'b1, 8'h30, 1'b1); idle(9);
    step(1'b1, 8'h99, 1'b1); idle(9);
    step(1'b1, 8'h00, 1'b1); idle(9);
    step(1'b1, 8'h3A, 1'b1); idle(9);
    step(1'b1, 8'hF0, 1'b1); idle(9);

    // Operand during conversion is dropped; re-presented at E10 it is taken.
    step(1'b1, 8'h42, 1'b1); idle(2);
    step(1'b1, 8'h17, 1'b1); idle(6);
    step(1'b1, 8'h17, 1'b1); idle(10);

    // Reset mid-conversion aborts the operand.
    step(1'b1, 8'h55, 1'b1); idle(3);
    step(1'b0, 8'h00, 1'b0); idle(2);
    step(1'b1, 8'h12, 1'b1); idle(10);

    // Sweep every two-digit value back to back at full throughput.
    for (int i = 0; i < 100; i++) begin
      dd = 8'((i / 10) * 16 + (i % 10));
      step(1'b1, dd, 1'b1);
      idle(BW + 1);
    end

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) dd = 8'($urandom_range(0, 255));
      else dd = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
      step(($urandom_range(0, 2) == 0), dd, ($urandom_range(0, 99) != 0));
    end
    idle(12);

    chk_en = 0;
    run6(8'h64, 0, 1'b1);
    run6(8'h63, 63, 1'b0);
    run6(8'h07, 7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
